tinyriscv_soc: RTL and testbench



---
 rtl/tinyriscv_soc.sv | 263 ++++++++++++++++++++++++++
 tb/tb_tinyriscv_soc.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/tinyriscv_soc.sv
// Single-cycle RV32I core with a unified 16 KB instruction/data memory.
// Fetch, decode, execute and memory read settle within one cycle; state commits on the rising edge.

module tinyriscv_soc (
    input logic clk,
    input logic rst
);
    localparam int unsigned AW = 12;

    logic [AW-1:0] inst_addr;
    logic [31:0]   inst;
    logic [AW-1:0] data_addr;
    logic [31:0]   data_rdata;
    logic [31:0]   data_wdata;
    logic [3:0]    data_be;

    tinyriscv u_tinyriscv (
        .clk          (clk),
        .rst          (rst),
        .inst         (inst),
        .data_rdata   (data_rdata),
        .inst_addr_c  (inst_addr),
        .data_addr_c  (data_addr),
        .data_wdata_c (data_wdata),
        .data_be_c    (data_be)
    );

    tinyriscv_rom u_rom (
        .clk        (clk),
        .inst_addr  (inst_addr),
        .inst       (inst),
        .data_addr  (data_addr),
        .data_rdata (data_rdata),
        .data_be    (data_be),
        .data_wdata (data_wdata)
    );
endmodule

module tinyriscv (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic [31:0] data_rdata,
    output logic [11:0] inst_addr_c,
    output logic [11:0] data_addr_c,
    output logic [31:0] data_wdata_c,
    output logic [3:0]  data_be_c
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_data, rs2_data;
    logic        rd_we;
    logic [31:0] rd_data;
    logic [31:0] mem_addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        taken;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        unused_addr_hi;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'b0};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    tinyriscv_regs u_regs (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data),
        .we     (rd_we),
        .waddr  (rd),
        .wdata  (rd_data)
    );

    // Shared by OP and OP-IMM; alt selects SUB or SRA/SRAI.
    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0]        r;
        logic signed [31:0] sra_r;
        sra_r = $signed(a) >>> b[4:0];
        case (f3)
            3'b000:  r = alt ? (a - b) : (a + b);
            3'b001:  r = a << b[4:0];
            3'b010:  r = {31'b0, $signed(a) < $signed(b)};
            3'b011:  r = {31'b0, a < b};
            3'b100:  r = a ^ b;
            3'b101: begin
                if (alt) r = 32'(sra_r);
                else     r = a >> b[4:0];
            end
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    always_comb begin
        next_pc  = pc + 32'd4;
        rd_we    = 1'b0;
        rd_data  = '0;
        mem_addr = rs1_data + imm_i;
        wdata    = '0;
        be       = '0;
        taken    = 1'b0;
        ld_byte  = 8'(data_rdata >> {mem_addr[1:0], 3'b000});
        ld_half  = mem_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
        case (opcode)
            OP_LUI: begin
                rd_we   = 1'b1;
                rd_data = imm_u;
            end
            OP_AUIPC: begin
                rd_we   = 1'b1;
                rd_data = pc + imm_u;
            end
            OP_JAL: begin
                rd_we   = 1'b1;
                rd_data = pc + 32'd4;
                next_pc = pc + imm_j;
            end
            OP_JALR: begin
                rd_we   = 1'b1;
                rd_data = pc + 32'd4;
                next_pc = (rs1_data + imm_i) & ~32'd1;
            end
            OP_BRANCH: begin
                case (funct3)
                    3'b000:  taken = rs1_data == rs2_data;
                    3'b001:  taken = rs1_data != rs2_data;
                    3'b100:  taken = $signed(rs1_data) <  $signed(rs2_data);
                    3'b101:  taken = $signed(rs1_data) >= $signed(rs2_data);
                    3'b110:  taken = rs1_data <  rs2_data;
                    3'b111:  taken = rs1_data >= rs2_data;
                    default: taken = 1'b0;
                endcase
                if (taken) next_pc = pc + imm_b;
            end
            OP_LOAD: begin
                rd_we = 1'b1;
                case (funct3)
                    3'b000:  rd_data = {{24{ld_byte[7]}}, ld_byte};
                    3'b001:  rd_data = {{16{ld_half[15]}}, ld_half};
                    3'b010:  rd_data = data_rdata;
                    3'b100:  rd_data = {24'b0, ld_byte};
                    3'b101:  rd_data = {16'b0, ld_half};
                    default: rd_we   = 1'b0;
                endcase
            end
            OP_STORE: begin
                mem_addr = rs1_data + imm_s;
                case (funct3)
                    3'b000: begin
                        be    = 4'b0001 << mem_addr[1:0];
                        wdata = {4{rs2_data[7:0]}};
                    end
                    3'b001: begin
                        be    = mem_addr[1] ? 4'b1100 : 4'b0011;
                        wdata = {2{rs2_data[15:0]}};
                    end
                    3'b010: begin
                        be    = 4'b1111;
                        wdata = rs2_data;
                    end
                    default: be = '0;
                endcase
            end
            OP_IMM: begin
                rd_we   = 1'b1;
                rd_data = alu(funct3, (funct3 == 3'b101) && inst[30], rs1_data, imm_i);
            end
            OP_REG: begin
                rd_we   = 1'b1;
                rd_data = alu(funct3, inst[30], rs1_data, rs2_data);
            end
            default: rd_we = 1'b0;
        endcase
    end

    // Stores are dropped on any edge where reset is asserted.
    assign inst_addr_c    = pc[13:2];
    assign data_addr_c    = mem_addr[13:2];
    assign data_wdata_c   = wdata;
    assign data_be_c      = be & {4{~rst}};
    assign unused_addr_hi = ^mem_addr[31:14];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc <= '0;
        else     pc <= next_pc;
    end
endmodule

module tinyriscv_regs (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);
    logic [31:0] regs [0:31];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];
endmodule

module tinyriscv_rom (
    input  logic        clk,
    input  logic [11:0] inst_addr,
    output logic [31:0] inst,
    input  logic [11:0] data_addr,
    output logic [31:0] data_rdata,
    input  logic [3:0]  data_be,
    input  logic [31:0] data_wdata
);
    localparam int unsigned DEPTH = 4096;

    logic [31:0] _rom [0:DEPTH-1];

    // Byte-lane write; contents survive reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (data_be[b]) _rom[data_addr][b*8 +: 8] <= data_wdata[b*8 +: 8];
        end
    end

    assign inst       = _rom[inst_addr];
    assign data_rdata = _rom[data_addr];
endmodule

// File: tb/tb_tinyriscv_soc.sv
// Directed-program bench: expected architectural state is queued per retire cycle and checked by a monitor.

module tb_tinyriscv_soc;
    localparam int K_REG = 0;
    localparam int K_PC  = 1;
    localparam int K_MEM = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc;
    int   checks = 0;
    int   passed = 0;

    typedef struct packed {
        int          cyc;
        int          kind;
        int          idx;
        logic [31:0] exp;
    } chk_t;

    chk_t sb[$];

    always #5 clk = ~clk;

    tinyriscv_soc dut (
        .clk (clk),
        .rst (rst)
    );

    // Retire counter: edge n executes the n-th instruction after reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic [31:0] read_state(input int kind, input int idx);
        logic [31:0] v;
        case (kind)
            K_REG:   v = dut.u_tinyriscv.u_regs.regs[idx[4:0]];
            K_PC:    v = dut.u_tinyriscv.pc;
            default: v = dut.u_rom._rom[idx[11:0]];
        endcase
        return v;
    endfunction

    task automatic expect_at(input int at, input int kind, input int idx, input logic [31:0] exp);
        sb.push_back('{cyc: at, kind: kind, idx: idx, exp: exp});
    endtask

    // Monitor: compares every queued expectation whose cycle has been reached.
    always @(negedge clk) begin
        chk_t        c;
        logic [31:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            c   = sb.pop_front();
            act = read_state(c.kind, c.idx);
            checks++;
            if (act === c.exp) begin
                passed++;
            end else begin
                case (c.kind)
                    K_REG:   $display("FAIL x%0d @cyc%0d: got %08h want %08h", c.idx, c.cyc, act, c.exp);
                    K_PC:    $display("FAIL pc @cyc%0d: got %08h want %08h", c.cyc, act, c.exp);
                    default: $display("FAIL mem[%0d] @cyc%0d: got %08h want %08h", c.idx, c.cyc, act, c.exp);
                endcase
            end
        end
    end

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d checks pending after %0d cycles", sb.size(), budget);
            sb.delete();
        end
    endtask

    logic [31:0] prog [0:36] = '{
        32'hFFF00093, 32'h01C0D113, 32'h41C0D193, 32'h00103233,  // addi/srli/srai/sltu
        32'h008000EF, 32'h00C0006F, 32'h00108067, 32'h00700393,  // jal x1,+8 / jal x0,+12 / jalr x0,x1,1 / skipped
        32'h00500013, 32'hFFF00413, 32'h00100493, 32'h00944463,  // addi x0 / x8=-1 / x9=1 / blt
        32'h00100513, 32'h00946463, 32'h00100593, 32'h80FF8637,  // skipped / bltu / x11=1 / lui
        32'hF0160613, 32'h000026B7, 32'h00C6A023, 32'h00368703,  // x12=80FF7F01 / x13=2000 / sw / lb
        32'h0036C783, 32'h00269803, 32'h0AA00893, 32'h011680A3,  // lbu / lh / x17=AA / sb
        32'h0006A903, 32'h000069B7, 32'h01199123, 32'h0006AA03,  // lw / x19=6000 / sh alias / lw
        32'h0026DA83, 32'h00001B17, 32'h40848BB3, 32'h40965C33,  // lhu / auipc / sub / sra
        32'h00942CB3, 32'h00100D13, 32'h00100D93, 32'h00000073,  // slt / x26 / x27 / ecall
        32'h0000006F                                             // jal x0,0
    };

    initial begin
        for (int i = 0; i < 4096; i++) dut.u_rom._rom[i] <= (i < 37) ? prog[i] : 32'h0;

        #1 rst = 1'b1;
        expect_at(0, K_PC, 0, 32'h0);
        expect_at(0, K_REG, 1, 32'h0);
        expect_at(0, K_REG, 31, 32'h0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        expect_at(1,  K_REG, 1,  32'hFFFFFFFF);
        expect_at(1,  K_PC,  0,  32'h00000004);
        expect_at(4,  K_REG, 2,  32'h0000000F);
        expect_at(4,  K_REG, 3,  32'hFFFFFFFF);
        expect_at(4,  K_REG, 4,  32'h00000001);
        expect_at(5,  K_REG, 1,  32'h00000014);
        expect_at(5,  K_PC,  0,  32'h00000018);
        expect_at(6,  K_PC,  0,  32'h00000014);
        expect_at(7,  K_PC,  0,  32'h00000020);
        expect_at(8,  K_REG, 0,  32'h00000000);
        expect_at(11, K_PC,  0,  32'h00000034);
        expect_at(12, K_PC,  0,  32'h00000038);
        expect_at(13, K_REG, 11, 32'h00000001);
        expect_at(15, K_REG, 12, 32'h80FF7F01);
        expect_at(17, K_MEM, 12'h800, 32'h80FF7F01);
        expect_at(18, K_REG, 14, 32'hFFFFFF80);
        expect_at(19, K_REG, 15, 32'h00000080);
        expect_at(20, K_REG, 16, 32'hFFFF80FF);
        expect_at(23, K_REG, 18, 32'h80FFAA01);
        expect_at(40, K_REG, 7,  32'h00000000);
        expect_at(40, K_REG, 10, 32'h00000000);
        expect_at(40, K_REG, 20, 32'h00AAAA01);
        expect_at(40, K_REG, 21, 32'h000000AA);
        expect_at(40, K_REG, 22, 32'h00001074);
        expect_at(40, K_REG, 23, 32'h00000002);
        expect_at(40, K_REG, 24, 32'hC07FBF80);
        expect_at(40, K_REG, 25, 32'h00000001);
        expect_at(40, K_REG, 26, 32'h00000001);
        expect_at(40, K_REG, 27, 32'h00000001);
        expect_at(40, K_REG, 3,  32'hFFFFFFFF);
        expect_at(40, K_MEM, 12'h800, 32'h00AAAA01);
        expect_at(40, K_PC,  0,  32'h00000090);
        drain(100);

        // Asynchronous reset in the middle of a clock-high phase.
        @(posedge clk);
        #2 rst = 1'b1;
        expect_at(0, K_PC,  0,  32'h0);
        expect_at(0, K_REG, 1,  32'h0);
        expect_at(0, K_REG, 26, 32'h0);
        expect_at(0, K_REG, 27, 32'h0);
        expect_at(0, K_MEM, 12'h800, 32'h00AAAA01);
        expect_at(0, K_MEM, 0,  32'hFFF00093);
        drain(10);
        @(negedge clk);
        #1 rst = 1'b0;
        expect_at(1, K_REG, 1, 32'hFFFFFFFF);
        expect_at(1, K_PC,  0, 32'h00000004);
        expect_at(2, K_REG, 2, 32'h0000000F);
        drain(10);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
